// File: rtl/mul_iter_unit_if.sv
// mul_iter_unit_if: EX-stage handshake and operand bundle for mul_iter_unit.
//   start    : EX holds a multiply instruction
//   flush    : kill any in-flight multiply (taken branch/jump)
//   mul_ctrl : 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//   src1/2   : forwarded rs1/rs2 operands
//   stall    : freeze IF/ID/EX (combinational)
//   busy     : operation in flight (registered)
//   valid    : one-cycle result strobe (registered)
//   result   : product word, held until the next valid
// master = pipeline side, slave = multiplier.
interface mul_iter_unit_if;
  logic        start;
  logic        flush;
  logic [1:0]  mul_ctrl;
  logic [31:0] src1;
  logic [31:0] src2;
  logic        stall;
  logic        busy;
  logic        valid;
  logic [31:0] result;

  modport master (
    output start, flush, mul_ctrl, src1, src2,
    input  stall, busy, valid, result
  );

  modport slave (
    input  start, flush, mul_ctrl, src1, src2,
    output stall, busy, valid, result
  );
endinterface

// File: rtl/mul_iter_unit.sv
// mul_iter_unit: iterative RV32M multiplier (MUL/MULH/MULHSU/MULHU) for EX.
// Operands are converted to magnitudes at start, multiplied unsigned by
// shift-add over N iterations, then the sign is applied in a final step.
// Ports:
//   clk    : system clock
//   rst    : synchronous active-high reset
//   mul_if : mul_iter_unit_if.slave (start/flush/mul_ctrl/src1/src2 in,
//            stall/busy/valid/result out)
// Configuration macro MUL_RADIX4_EN:
//   defined   -> radix-4, 2 bits of B per cycle, 16 iterations (18-cycle latency)
//   undefined -> radix-2, 1 bit of B per cycle, 32 iterations (34-cycle latency)
module mul_iter_unit (
  input  logic           clk,
  input  logic           rst,
  mul_iter_unit_if.slave mul_if
);

`ifdef MUL_RADIX4_EN
  localparam int unsigned R = 2;
  localparam int unsigned N = 16;
`else
  localparam int unsigned R = 1;
  localparam int unsigned N = 32;
`endif
  localparam logic [5:0] N_CNT = 6'(N);

  typedef enum logic [1:0] {IDLE, CALC, SIGN} state_t;

  state_t      state_q, state_d;
  logic [65:0] acc_q;
  logic [65:0] a_q;        // magnitude of A, shifted left R bits per iteration
`ifdef MUL_RADIX4_EN
  logic [65:0] a3_q;       // 3A, shifted alongside a_q
`endif
  logic [31:0] b_q;        // magnitude of B, consumed LSB first
  logic [5:0]  cnt_q;
  logic        neg_q;
  logic [1:0]  ctrl_q;
  logic        busy_q;
  logic        valid_q;
  logic [31:0] result_q;

  logic        accept;
  logic        sign_a, sign_b;
  logic [31:0] mag_a, mag_b;
  logic [65:0] pp;
  logic [65:0] acc_d;
  logic [65:0] prod_d;
  logic [31:0] result_d;
  logic        stall;

  // Operand conditioning: only the signed operands of MULH/MULHSU are
  // converted to magnitude; MUL and MULHU pass through unchanged.
  always_comb begin
    sign_a = mul_if.src1[31] & ((mul_if.mul_ctrl == 2'b01) | (mul_if.mul_ctrl == 2'b10));
    sign_b = mul_if.src2[31] & (mul_if.mul_ctrl == 2'b01);
    mag_a  = sign_a ? (~mul_if.src1 + 32'd1) : mul_if.src1;
    mag_b  = sign_b ? (~mul_if.src2 + 32'd1) : mul_if.src2;
  end

  // The !valid term keeps the instruction whose result is strobing from
  // being accepted a second time while it is still in EX.
  assign accept = (state_q == IDLE) & mul_if.start & ~mul_if.flush & ~valid_q;

  // Partial product for the current iteration.
  always_comb begin
    pp = '0;
`ifdef MUL_RADIX4_EN
    unique case (b_q[1:0])
      2'b00: pp = '0;
      2'b01: pp = a_q;
      2'b10: pp = a_q << 1;
      2'b11: pp = a3_q;
    endcase
`else
    if (b_q[0]) pp = a_q;
`endif
  end

  assign acc_d = acc_q + pp;

  // Sign fix-up and word select; the shift-then-cast keeps the guard bits
  // of the accumulator out of the result without a separate slice.
  always_comb begin
    prod_d   = neg_q ? (~acc_q + 66'd1) : acc_q;
    result_d = 32'(prod_d >> ((ctrl_q == 2'b00) ? 7'd0 : 7'd32));
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = CALC;
      CALC: begin
        if (mul_if.flush)       state_d = IDLE;
        else if (cnt_q == 6'd1) state_d = SIGN;
      end
      SIGN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic.
  always_comb begin
    stall = 1'b0;
    if (state_q != IDLE) stall = 1'b1;
    else                 stall = mul_if.start & ~mul_if.flush & ~valid_q;
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q    <= '0;
      a_q      <= '0;
`ifdef MUL_RADIX4_EN
      a3_q     <= '0;
`endif
      b_q      <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      ctrl_q   <= 2'b00;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      result_q <= '0;
    end else begin
      valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            a_q    <= {34'd0, mag_a};
`ifdef MUL_RADIX4_EN
            a3_q   <= {34'd0, mag_a} + {33'd0, mag_a, 1'b0};
`endif
            b_q    <= mag_b;
            neg_q  <= sign_a ^ sign_b;
            ctrl_q <= mul_if.mul_ctrl;
            acc_q  <= '0;
            cnt_q  <= N_CNT;
            busy_q <= 1'b1;
          end
        end
        CALC: begin
          if (mul_if.flush) begin
            busy_q <= 1'b0;
          end else begin
            acc_q <= acc_d;
            a_q   <= a_q << R;
`ifdef MUL_RADIX4_EN
            a3_q  <= a3_q << R;
`endif
            b_q   <= b_q >> R;
            cnt_q <= cnt_q - 6'd1;
          end
        end
        SIGN: begin
          busy_q <= 1'b0;
          if (!mul_if.flush) begin
            result_q <= result_d;
            valid_q  <= 1'b1;
          end
        end
        default: busy_q <= 1'b0;
      endcase
    end
  end

  assign mul_if.stall  = stall;
  assign mul_if.busy   = busy_q;
  assign mul_if.valid  = valid_q;
  assign mul_if.result = result_q;

endmodule

// File: tb/tb_mul_iter_unit.sv
// tb_mul_iter_unit: directed self-checking bench for mul_iter_unit.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_mul_iter_unit;

`ifdef MUL_RADIX4_EN
  localparam int N = 16;
`else
  localparam int N = 32;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mul_iter_unit_if bus ();

  mul_iter_unit dut (
    .clk    (clk),
    .rst    (rst),
    .mul_if (bus)
  );

  int errors = 0;
  int checks = 0;
  logic [31:0] last_res = 32'h0;

  // One multiply: start is held until the valid cycle, as a stalled pipeline would.
  // Returns at the falling edge of the valid cycle with start still high.
  task automatic do_mul(input logic [1:0] ctrl, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input string name);
    int lat;
    int stall_cnt;
    bit seen;
    @(negedge clk);
    bus.start = 1'b1; bus.flush = 1'b0; bus.mul_ctrl = ctrl; bus.src1 = a; bus.src2 = b;
    #1;
    checks++;
    if (bus.stall !== 1'b1) begin
      errors++; $display("FAIL %s start_stall: got %b want 1", name, bus.stall);
    end
    checks++;
    if (bus.valid !== 1'b0) begin
      errors++; $display("FAIL %s start_valid: got %b want 0", name, bus.valid);
    end
    lat = 0; stall_cnt = 0; seen = 1'b0;
    for (int k = 1; k <= N + 4 && !seen; k++) begin
      @(negedge clk);
      if (k == 1) begin
        checks++;
        if (bus.busy !== 1'b1) begin
          errors++; $display("FAIL %s busy_after_start: got %b want 1", name, bus.busy);
        end
      end
      if (bus.valid === 1'b1) begin
        seen = 1'b1; lat = k;
      end else if (bus.stall === 1'b1) begin
        stall_cnt++;
      end
    end
    checks++;
    if (lat != N + 2) begin
      errors++; $display("FAIL %s latency: got %0d want %0d", name, lat, N + 2);
    end
    checks++;
    if (bus.result !== exp) begin
      errors++; $display("FAIL %s result: got %h want %h", name, bus.result, exp);
    end
    checks++;
    if (bus.stall !== 1'b0) begin
      errors++; $display("FAIL %s valid_stall: got %b want 0", name, bus.stall);
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++; $display("FAIL %s valid_busy: got %b want 0", name, bus.busy);
    end
    checks++;
    if (stall_cnt != N + 1) begin
      errors++; $display("FAIL %s stall_cycles: got %0d want %0d", name, stall_cnt, N + 1);
    end
    last_res = exp;
  endtask

  // Instruction leaves EX; the unit must not have restarted on it.
  task automatic end_op(input string name);
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.valid !== 1'b0) begin
      errors++; $display("FAIL %s no_restart: got busy=%b valid=%b want 0 0", name, bus.busy, bus.valid);
    end
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.start = 1'b0; bus.flush = 1'b0; bus.mul_ctrl = 2'b00;
    bus.src1 = '0; bus.src2 = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.valid !== 1'b0 || bus.stall !== 1'b0) begin
      errors++; $display("FAIL reset_ctrl: got busy=%b valid=%b stall=%b want 0 0 0", bus.busy, bus.valid, bus.stall);
    end
    checks++;
    if (bus.result !== 32'h0) begin
      errors++; $display("FAIL reset_result: got %h want 00000000", bus.result);
    end
    bus.start = 1'b1; #1;
    checks++;
    if (bus.stall !== 1'b1) begin
      errors++; $display("FAIL reset_stall_start: got %b want 1", bus.stall);
    end
    bus.start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    do_mul(2'b00, 32'd7, 32'd6, 32'h0000002A, "mul_7x6");
    end_op("mul_7x6");
    do_mul(2'b00, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFF1, "mul_m3x5");
    end_op("mul_m3x5");
    do_mul(2'b00, 32'h12345678, 32'h10, 32'h23456780, "mul_shift");
    end_op("mul_shift");
  endtask

  task automatic test_signed();
    do_mul(2'b01, 32'h80000000, 32'h80000000, 32'h40000000, "mulh_min");
    end_op("mulh_min");
    do_mul(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, "mulh_m1");
    end_op("mulh_m1");
    do_mul(2'b01, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, "mulh_max");
    end_op("mulh_max");
    do_mul(2'b01, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, "mulh_m3x5");
    end_op("mulh_m3x5");
    do_mul(2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, "mulhsu_m1");
    end_op("mulhsu_m1");
    do_mul(2'b10, 32'h80000000, 32'd2, 32'hFFFFFFFF, "mulhsu_min2");
    end_op("mulhsu_min2");
    do_mul(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, "mulhu_max");
    end_op("mulhu_max");
    do_mul(2'b11, 32'h80000000, 32'd4, 32'h00000002, "mulhu_big");
    end_op("mulhu_big");
    do_mul(2'b11, 32'h12345678, 32'h10, 32'h00000001, "mulhu_shift");
    end_op("mulhu_shift");
  endtask

  task automatic test_flush();
    int vcnt;
    // Flush in CALC cycle 10.
    @(negedge clk);
    bus.start = 1'b1; bus.flush = 1'b0; bus.mul_ctrl = 2'b00; bus.src1 = 32'd3; bus.src2 = 32'd5;
    for (int k = 1; k <= 10; k++) @(negedge clk);
    bus.flush = 1'b1; #1;
    checks++;
    if (bus.stall !== 1'b1) begin
      errors++; $display("FAIL flush_calc_stall: got %b want 1", bus.stall);
    end
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.valid !== 1'b0) begin
      errors++; $display("FAIL flush_calc_ctrl: got busy=%b valid=%b want 0 0", bus.busy, bus.valid);
    end
    checks++;
    if (bus.result !== last_res) begin
      errors++; $display("FAIL flush_calc_result: got %h want %h", bus.result, last_res);
    end
    bus.flush = 1'b0; bus.start = 1'b0; #1;
    checks++;
    if (bus.stall !== 1'b0) begin
      errors++; $display("FAIL flush_calc_stall_after: got %b want 0", bus.stall);
    end
    vcnt = 0;
    for (int k = 0; k < N + 4; k++) begin
      @(negedge clk);
      if (bus.valid === 1'b1) vcnt++;
    end
    checks++;
    if (vcnt != 0 || bus.result !== last_res) begin
      errors++; $display("FAIL flush_calc_late: got valids=%0d result=%h want 0 %h", vcnt, bus.result, last_res);
    end
    // Flush and start together in IDLE: nothing accepted.
    @(negedge clk);
    bus.start = 1'b1; bus.flush = 1'b1; #1;
    checks++;
    if (bus.stall !== 1'b0) begin
      errors++; $display("FAIL flush_idle_stall: got %b want 0", bus.stall);
    end
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++; $display("FAIL flush_idle_busy: got %b want 0", bus.busy);
    end
    bus.start = 1'b0; bus.flush = 1'b0;
    // Flush during SIGN: no valid, result untouched.
    @(negedge clk);
    bus.start = 1'b1; bus.mul_ctrl = 2'b00; bus.src1 = 32'd3; bus.src2 = 32'd5;
    for (int k = 1; k <= N + 1; k++) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b1 || bus.valid !== 1'b0) begin
      errors++; $display("FAIL flush_sign_pre: got busy=%b valid=%b want 1 0", bus.busy, bus.valid);
    end
    bus.flush = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.valid !== 1'b0 || bus.busy !== 1'b0 || bus.result !== last_res) begin
      errors++; $display("FAIL flush_sign: got valid=%b busy=%b result=%h want 0 0 %h", bus.valid, bus.busy, bus.result, last_res);
    end
    bus.flush = 1'b0; bus.start = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.valid !== 1'b0) begin
      errors++; $display("FAIL flush_sign_late: got %b want 0", bus.valid);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    bus.start = 1'b1; bus.mul_ctrl = 2'b00; bus.src1 = 32'd6; bus.src2 = 32'd7;
    for (int k = 1; k <= 5; k++) @(negedge clk);
    rst = 1'b1; bus.start = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.valid !== 1'b0 || bus.stall !== 1'b0) begin
      errors++; $display("FAIL rst_mid_ctrl: got busy=%b valid=%b stall=%b want 0 0 0", bus.busy, bus.valid, bus.stall);
    end
    checks++;
    if (bus.result !== 32'h0) begin
      errors++; $display("FAIL rst_mid_result: got %h want 00000000", bus.result);
    end
    rst = 1'b0;
    do_mul(2'b00, 32'd2, 32'd2, 32'h00000004, "mul_after_rst");
    end_op("mul_after_rst");
  endtask

  task automatic test_back_to_back();
    do_mul(2'b00, 32'd9, 32'd9, 32'h00000051, "b2b_first");
    do_mul(2'b00, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFE, "b2b_second");
    end_op("b2b_second");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signed();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
